// File: rtl/rect_fill.sv
// Rectangle fill engine: latches two corners and a colour, then writes every
// pixel of the clipped rectangle row-major, one framebuffer write per cycle.
module rect_fill #(
  parameter int FB_WIDTH  = 214,
  parameter int FB_HEIGHT = 160,
  parameter int A_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               execute_request,
  input  logic [7:0]         x0,
  input  logic [7:0]         x1,
  input  logic [7:0]         y0,
  input  logic [7:0]         y1,
  input  logic [2:0]         colour,
  output logic               ready,
  output logic               done,
  output logic [A_WIDTH-1:0] fb_addr,
  output logic               fb_write_en,
  output logic [2:0]         fb_pixel
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [A_WIDTH-1:0] W_A = A_WIDTH'(FB_WIDTH);

  state_t             state, state_nxt;
  logic [7:0]         x0_q, x1_q, y0_q, y1_q;
  logic [2:0]         colour_q;
  logic [7:0]         xmin, xmax, ymax, x, y;
  logic [A_WIDTH-1:0] row_base;

  logic [7:0] s_xmin, s_xmax, s_ymin, s_ymax;
  logic       s_off, row_end, last;

  // Corner ordering and clipping, evaluated from the latched corners in SETUP.
  always_comb begin
    s_xmin = (x0_q < x1_q) ? x0_q : x1_q;
    s_xmax = (x0_q < x1_q) ? x1_q : x0_q;
    s_ymin = (y0_q < y1_q) ? y0_q : y1_q;
    s_ymax = (y0_q < y1_q) ? y1_q : y0_q;
    if (int'(s_xmax) > FB_WIDTH - 1)  s_xmax = 8'(FB_WIDTH - 1);
    if (int'(s_ymax) > FB_HEIGHT - 1) s_ymax = 8'(FB_HEIGHT - 1);
    s_off = (int'(s_xmin) >= FB_WIDTH) || (int'(s_ymin) >= FB_HEIGHT);
  end

  assign row_end = (x == xmax);
  assign last    = row_end && (y == ymax);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (execute_request) state_nxt = SETUP;
      SETUP: state_nxt = s_off ? DONE : FILL;
      FILL:  if (last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign ready       = (state == IDLE);
  assign done        = (state == DONE);
  assign fb_write_en = (state == FILL);
  assign fb_pixel    = colour_q;

  // The only multiply happens once in SETUP; FILL walks addresses by adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
      colour_q <= '0;
      xmin <= '0; xmax <= '0; ymax <= '0; x <= '0; y <= '0;
      row_base <= '0;
      fb_addr  <= '0;
    end else begin
      case (state)
        IDLE: if (execute_request) begin
          x0_q <= x0; x1_q <= x1; y0_q <= y0; y1_q <= y1;
          colour_q <= colour;
        end
        SETUP: begin
          xmin     <= s_xmin;
          xmax     <= s_xmax;
          ymax     <= s_ymax;
          x        <= s_xmin;
          y        <= s_ymin;
          row_base <= A_WIDTH'(s_ymin) * W_A;
          fb_addr  <= A_WIDTH'(s_ymin) * W_A + A_WIDTH'(s_xmin);
        end
        FILL: if (!last) begin
          if (row_end) begin
            x        <= xmin;
            y        <= y + 8'd1;
            row_base <= row_base + W_A;
            fb_addr  <= row_base + W_A + A_WIDTH'(xmin);
          end else begin
            x       <= x + 8'd1;
            fb_addr <= fb_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboard bench for rect_fill: stimulus pushes expected writes/done events
// with their cycle stamps; a negedge monitor pops and compares them.
module tb_rect_fill;
  localparam int W = 214;
  localparam int H = 160;

  logic        clk = 0;
  logic        rst;
  logic        execute_request;
  logic [7:0]  x0, x1, y0, y1;
  logic [2:0]  colour;
  logic        ready, done, fb_write_en;
  logic [15:0] fb_addr;
  logic [2:0]  fb_pixel;

  rect_fill #(.FB_WIDTH(W), .FB_HEIGHT(H), .A_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .execute_request(execute_request),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour),
    .ready(ready), .done(done), .fb_addr(fb_addr),
    .fb_write_en(fb_write_en), .fb_pixel(fb_pixel)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_done; int cyc; int addr; int pix;} ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (fb_write_en || done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: we=%0b done=%0b addr=%0d at cycle %0d, expected none",
                 fb_write_en, done, fb_addr, cyc);
      end else begin
        ev_t ev;
        ev = q.pop_front();
        chk("event_kind_done", int'(done), int'(ev.is_done));
        chk("event_cycle", cyc, ev.cyc);
        if (!ev.is_done) begin
          chk("fb_addr", int'(fb_addr), ev.addr);
          chk("fb_pixel", int'(fb_pixel), ev.pix);
        end
      end
    end
  end

  // Called at a negedge; waits for ready, issues the request, and models it.
  task automatic fire(input int ax0, ax1, ay0, ay1, acol, input bit keep,
                      output int acc);
    int t, xl, xh, yl, yh, n;
    t = 0;
    acc = 0;
    while (!ready && t < 40000) begin @(negedge clk); t++; end
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: ready=0 after %0d cycles, expected 1", t);
      return;
    end
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 8'(ay0); y1 = 8'(ay1);
    colour = 3'(acol);
    execute_request = 1;
    acc = cyc;
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    n = 0;
    if (xl < W && yl < H)
      for (int yy = yl; yy <= yh; yy++)
        for (int xx = xl; xx <= xh; xx++) begin
          q.push_back('{1'b0, acc + 2 + n, yy * W + xx, acol});
          n++;
        end
    q.push_back('{1'b1, acc + 2 + n, 0, 0});
    @(negedge clk);
    if (!keep) execute_request = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40000) begin @(negedge clk); t++; end
    chk("drain_pending_events", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc;
    rst = 1; execute_request = 1;
    x0 = 0; x1 = 0; y0 = 0; y1 = 0; colour = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    execute_request = 0;
    chk("reset_ready", int'(ready), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_we", int'(fb_write_en), 0);
    chk("reset_addr", int'(fb_addr), 0);
    chk("reset_pixel", int'(fb_pixel), 0);
    rst = 0;
    @(negedge clk);

    // Single pixel, with ready/done timing checked directly.
    fire(5, 5, 7, 7, 3'b101, 0, acc);
    @(negedge clk);
    chk("single_ready_during_write", int'(ready), 0);
    @(negedge clk);
    chk("single_done_pulse", int'(done), 1);
    chk("single_ready_in_done", int'(ready), 0);
    @(negedge clk);
    chk("single_ready_back", int'(ready), 1);
    chk("single_done_cleared", int'(done), 0);
    drain();

    fire(10, 8, 2, 1, 6, 0, acc);       // swapped corners
    drain();
    fire(200, 255, 159, 200, 3, 0, acc); // clipped on both axes
    drain();
    fire(220, 230, 0, 5, 7, 0, acc);     // off-screen in x
    drain();
    fire(0, 10, 170, 180, 2, 0, acc);    // off-screen in y
    drain();

    // Request held high through a fill: second fill waits for ready.
    fire(0, 2, 0, 0, 2, 1, acc);
    fire(3, 4, 5, 5, 4, 0, acc);
    drain();

    fire(0, 213, 0, 159, 1, 0, acc);     // full screen
    drain();

    // Reset at the 100th write of a full-screen fill.
    fire(0, 213, 0, 159, 6, 0, acc);
    while (cyc != acc + 2 + 99) @(negedge clk);
    #1;
    rst = 1;
    q.delete();
    @(negedge clk);
    chk("abort_we", int'(fb_write_en), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_addr", int'(fb_addr), 0);
    rst = 0;
    repeat (3) @(negedge clk);
    fire(1, 1, 1, 1, 2, 0, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
